uart_rx_oversampled: RTL and testbench
======================================

UART_RX_OVERSAMPLED -- requirements
Module: uart_rx_oversampled

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, giving the data bits per frame (legal 5..9).
REQ-002 The block SHALL have parameter PARITY_MODE, default 1, selecting parity: 0 none, 1 even, 2 odd.
REQ-003 The block SHALL have parameter STOP_BITS, default 1, giving the stop bits checked (legal 1..2).
REQ-004 The block SHALL have parameter OVERSAMPLE, default 16, giving sample_en ticks per bit (even, legal 4..64).
REQ-005 The block SHALL have port clk, input, 1 bit: system clock, all state on its rising edge.
REQ-006 The block SHALL have port resetN, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-008 The block SHALL have port sample_en, input, 1 bit: single-clk tick at OVERSAMPLE x baud.
REQ-009 The block SHALL have port rx_en, input, 1 bit: permits start-bit detection.
REQ-010 The block SHALL have port data_out, output, DATA_BITS wide: last received data word.
REQ-011 The block SHALL have port data_valid, output, 1 bit: data_out and flags hold an unconsumed frame.
REQ-012 The block SHALL have port data_ready, input, 1 bit: consumer accepts the frame.
REQ-013 The block SHALL have ports parity_error, framing_error and overrun, output, 1 bit each: status of the presented frame.
REQ-014 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-015 rx SHALL pass a 2-flop synchronizer, both flops reset to 1; all decisions use the synchronized value.
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, BREAK; the tick counter and bit counter advance only on sample_en.
REQ-017 IDLE->START SHALL occur on a sample_en tick when rx_en=1 and synchronized rx=0; the tick counter clears.
REQ-018 START SHALL re-check rx at tick OVERSAMPLE/2-1: low -> DATA with the tick counter cleared; high -> IDLE, a glitch, no flags touched.
REQ-019 DATA, PARITY and STOP bits SHALL each be sampled once, at every OVERSAMPLE-th tick after the start midpoint; data is LSB first.
REQ-020 PARITY SHALL be skipped when PARITY_MODE=0; otherwise parity_error = (received parity bit != expected parity), where even parity means XOR(data, parity bit)=0.
REQ-021 Every stop bit SHALL be sampled; any low stop sample sets framing_error for the frame.
REQ-022 On the tick sampling the last stop bit, the next clk edge SHALL load data_out and the three flags, and SHALL set data_valid=1.
REQ-023 After that edge the FSM SHALL go to IDLE, or to BREAK when framing_error=1; BREAK SHALL exit to IDLE on the first sample_en tick with rx=1.
REQ-024 data_valid SHALL clear on the clk edge where data_valid & data_ready; data_out and the flags then hold their values.
REQ-025 A frame completing while data_valid=1 and data_ready=0 SHALL overwrite data_out and the flags and SHALL set overrun=1.
REQ-026 A frame completing on the same edge as an accept handshake SHALL leave data_valid=1 with overrun=0.
REQ-027 rx_en=0 SHALL block only new starts; a frame already in progress SHALL complete.
REQ-028 sample_en=0 SHALL freeze the FSM and counters; data_ready SHALL still be honoured.

Reset
REQ-029 resetN=0 SHALL immediately force IDLE, all counters 0, synchronizer flops 1, data_out 0, and data_valid, parity_error, framing_error, overrun and busy 0.
REQ-030 Reset mid-frame SHALL discard the partial frame without asserting data_valid; after release the next start edge is decoded normally.

Structure
REQ-031 The state enumeration and the PARITY_NONE/EVEN/ODD constants SHALL reside in a shared package uart_pkg, together with a parity function reused by the transmitter.
REQ-032 The synchronizer SHALL be a sub-module, sync_2ff.
REQ-033 Parameter legality SHALL be checked at elaboration, and an illegal value SHALL stop elaboration.

Verification
REQ-034 The bench SHALL send 8E1, OVERSAMPLE=16, byte 0xA5 with parity bit 0 -> data_out=0xA5, data_valid=1, all flags 0.
REQ-035 The bench SHALL send the same frame with parity bit 1 -> data_out=0xA5, parity_error=1.
REQ-036 The bench SHALL hold rx low for 4 ticks, then high -> busy returns 0, data_valid stays 0.
REQ-037 The bench SHALL send 0x3C with a low stop bit, then rx high -> framing_error=1, FSM passes through BREAK, then IDLE.
REQ-038 The bench SHALL send 0x11 then 0x22 with data_ready=0 -> data_out=0x22, overrun=1, data_valid=1; one data_ready pulse -> data_valid=0.
REQ-039 The bench SHALL pulse resetN low during data bit 3, then send 0x5A -> no frame before 0x5A, then data_out=0x5A.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity mode constants and
// the parity helper that transmitter and receiver both use.
package uart_pkg;

    localparam int PARITY_NONE   = 0;
    localparam int PARITY_EVEN   = 1;
    localparam int PARITY_ODD    = 2;
    localparam int MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    // Parity bit a transmitter appends; zero-extended data does not change the XOR.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                        input int                       mode);
        logic p;
        p = ^data;
        if (mode == PARITY_ODD)
            return ~p;
        else if (mode == PARITY_EVEN)
            return p;
        else
            return 1'b0;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; both flops reset to 1
// so an idle-high line never produces a false edge coming out of reset.
module sync_2ff (
    input  logic clk,
    input  logic resetN,
    input  logic d,
    output logic q
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            sync_q <= 2'b11;
        else
            sync_q <= {sync_q[0], d};
    end

    assign q = sync_q[1];

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampling UART receiver: start-bit midpoint qualification, mid-bit sampling
// of data/parity/stop, a one-deep output holding register with overrun flagging.
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = PARITY_EVEN,
    parameter int STOP_BITS   = 1,
    parameter int OVERSAMPLE  = 16
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 rx,
    input  logic                 sample_en,
    input  logic                 rx_en,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_error,
    output logic                 framing_error,
    output logic                 overrun,
    output logic                 busy
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam logic [TICK_W-1:0] HALF_TICK = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] FULL_TICK = TICK_W'(OVERSAMPLE - 1);
    localparam logic [3:0]        LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]        LAST_STOP = 4'(STOP_BITS - 1);

    generate
        if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS ||
            PARITY_MODE < PARITY_NONE || PARITY_MODE > PARITY_ODD ||
            STOP_BITS < 1 || STOP_BITS > 2 ||
            OVERSAMPLE < 4 || OVERSAMPLE > 64 || (OVERSAMPLE % 2) != 0) begin : g_bad_params
            $fatal(1, "uart_rx_oversampled: illegal parameter combination");
        end
    endgenerate

    logic                 rx_s;
    rx_state_t            state, state_nx;
    logic [TICK_W-1:0]    tick_cnt, tick_nx;
    logic [3:0]           bit_cnt, bit_nx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_acc, fe_acc;
    logic                 start_det, shift_en, par_load, fe_set, frame_done;

    sync_2ff u_sync (
        .clk    (clk),
        .resetN (resetN),
        .d      (rx),
        .q      (rx_s)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge resetN) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values, independent of process evaluation order.
        if (!resetN)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_nx   = state;
        tick_nx    = tick_cnt;
        bit_nx     = bit_cnt;
        start_det  = 1'b0;
        shift_en   = 1'b0;
        par_load   = 1'b0;
        fe_set     = 1'b0;
        frame_done = 1'b0;

        if (sample_en) begin
            unique case (state)
                IDLE: begin
                    if (rx_en && !rx_s) begin
                        start_det = 1'b1;
                        state_nx  = START;
                        tick_nx   = '0;
                        bit_nx    = '0;
                    end
                end
                START: begin
                    if (tick_cnt == HALF_TICK) begin
                        tick_nx  = '0;
                        state_nx = rx_s ? IDLE : DATA;
                    end else begin
                        tick_nx = tick_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_cnt == FULL_TICK) begin
                        tick_nx  = '0;
                        shift_en = 1'b1;
                        if (bit_cnt == LAST_DATA) begin
                            bit_nx   = '0;
                            state_nx = (PARITY_MODE == PARITY_NONE) ? STOP : PARITY;
                        end else begin
                            bit_nx = bit_cnt + 1'b1;
                        end
                    end else begin
                        tick_nx = tick_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (tick_cnt == FULL_TICK) begin
                        tick_nx  = '0;
                        par_load = 1'b1;
                        state_nx = STOP;
                    end else begin
                        tick_nx = tick_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_cnt == FULL_TICK) begin
                        tick_nx = '0;
                        fe_set  = !rx_s;
                        if (bit_cnt == LAST_STOP) begin
                            frame_done = 1'b1;
                            bit_nx     = '0;
                            state_nx   = (fe_acc || !rx_s) ? BREAK : IDLE;
                        end else begin
                            bit_nx = bit_cnt + 1'b1;
                        end
                    end else begin
                        tick_nx = tick_cnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (rx_s)
                        state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Counters and per-frame accumulators; cleared at every start detection.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_acc  <= 1'b0;
            fe_acc   <= 1'b0;
        end else begin
            tick_cnt <= tick_nx;
            bit_cnt  <= bit_nx;
            if (start_det) begin
                par_acc <= 1'b0;
                fe_acc  <= 1'b0;
            end
            if (shift_en)
                shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (par_load)
                par_acc <= (rx_s != parity_bit(MAX_DATA_BITS'(shreg), PARITY_MODE));
            if (fe_set)
                fe_acc <= 1'b1;
        end
    end

    // Output holding register: a new frame wins over a same-edge accept.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            data_out      <= '0;
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else if (frame_done) begin
            data_out      <= shreg;
            parity_error  <= par_acc;
            framing_error <= fe_acc | ~rx_s;
            overrun       <= data_valid & ~data_ready;
            data_valid    <= 1'b1;
        end else if (data_valid && data_ready) begin
            data_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboard bench for uart_rx_oversampled (8E1, 16x oversampling): stimulus pushes
// expected frames, a monitor pops and compares on every accept handshake.
module tb_uart_rx_oversampled;

    logic       clk = 1'b0;
    logic       resetN;
    logic       rx;
    logic       sample_en;
    logic       rx_en;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       parity_error;
    logic       framing_error;
    logic       overrun;
    logic       busy;

    typedef struct packed {
        logic [7:0] data;
        logic       pe;
        logic       fe;
        logic       ov;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   tick_count = 0;

    uart_rx_oversampled #(
        .DATA_BITS   (8),
        .PARITY_MODE (1),
        .STOP_BITS   (1),
        .OVERSAMPLE  (16)
    ) dut (
        .clk           (clk),
        .resetN        (resetN),
        .rx            (rx),
        .sample_en     (sample_en),
        .rx_en         (rx_en),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .data_ready    (data_ready),
        .parity_error  (parity_error),
        .framing_error (framing_error),
        .overrun       (overrun),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // One sample_en tick every 4 clocks.
    initial begin
        sample_en = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            sample_en = 1'b1;
            @(negedge clk);
            sample_en = 1'b0;
        end
    end

    always @(posedge clk)
        if (sample_en) tick_count <= tick_count + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        int target;
        target = tick_count + n;
        while (tick_count < target) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_ticks(16);
    endtask

    // Start, 8 data LSB first, even parity (optionally inverted), one stop bit.
    task automatic send_frame(input logic [7:0] d, input logic flip_par,
                              input logic stop_val, input logic drop_en_at_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit((^d) ^ flip_par);
        if (drop_en_at_stop) rx_en = 1'b0;
        send_bit(stop_val);
    endtask

    task automatic push_exp(input logic [7:0] d, input logic pe, input logic fe, input logic ov);
        exp_t e;
        e.data = d;
        e.pe   = pe;
        e.fe   = fe;
        e.ov   = ov;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
        check({name, "_drained"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Monitor: every accepted frame is compared against the scoreboard head.
    always @(negedge clk) begin
        if (resetN && data_valid && data_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_frame", {24'h0, data_out}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("frame_data",          data_out,      e.data);
                check("frame_parity_error",  parity_error,  e.pe);
                check("frame_framing_error", framing_error, e.fe);
                check("frame_overrun",       overrun,       e.ov);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetN     = 1'b0;
        rx         = 1'b1;
        rx_en      = 1'b1;
        data_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_data_out",      data_out,      0);
        check("reset_data_valid",    data_valid,    0);
        check("reset_busy",          busy,          0);
        check("reset_flags",         {parity_error, framing_error, overrun}, 0);
        resetN = 1'b1;
        wait_ticks(4);

        // Clean 8E1 frame, then the same frame with the parity bit inverted.
        push_exp(8'hA5, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        wait_ticks(4);
        wait_drain("a5_clean");

        push_exp(8'hA5, 1'b1, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        wait_ticks(4);
        wait_drain("a5_bad_parity");

        // Short low pulse: start qualification rejects it.
        rx = 1'b0;
        wait_ticks(3);
        check("glitch_busy_during", busy, 1);
        wait_ticks(1);
        rx = 1'b1;
        wait_ticks(16);
        check("glitch_busy_after",  busy,       0);
        check("glitch_no_valid",    data_valid, 0);

        // Low stop bit, line held low (break) with new starts disabled.
        push_exp(8'h3C, 1'b0, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        wait_ticks(8);
        check("break_hold_busy", busy, 1);
        rx = 1'b1;
        wait_ticks(4);
        check("break_exit_busy", busy, 0);
        rx_en = 1'b1;
        wait_drain("break_frame");
        wait_ticks(4);

        // Two frames with no consumer: second overwrites and flags overrun.
        data_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1, 1'b0);
        wait_ticks(4);
        send_frame(8'h22, 1'b0, 1'b1, 1'b0);
        wait_ticks(4);
        check("overrun_valid_held", data_valid, 1);
        push_exp(8'h22, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #2 data_ready = 1'b1;
        @(posedge clk);
        #2 data_ready = 1'b0;
        @(negedge clk);
        check("overrun_valid_cleared", data_valid, 0);
        wait_drain("overrun");
        data_ready = 1'b1;
        wait_ticks(4);

        // Reset during data bit 3 of a frame, then a clean frame.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        rx = 1'b0;
        wait_ticks(8);
        @(negedge clk);
        resetN = 1'b0;
        #2;
        check("midreset_busy",     busy,     0);
        check("midreset_data_out", data_out, 0);
        @(negedge clk);
        resetN = 1'b1;
        rx     = 1'b1;
        wait_ticks(20);
        check("postreset_busy",  busy,       0);
        check("postreset_valid", data_valid, 0);
        push_exp(8'h5A, 1'b0, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        wait_ticks(4);
        wait_drain("after_reset_5a");

        wait_ticks(4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
